// File: rtl/wb_master_if_if.sv
// Bundle of core-side request/response signals and Wishbone classic bus
// signals for wb_master_if. The master modport is the initiator's view and
// the slave modport is the view of the core/slave side that drives it.
interface wb_master_if_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   localparam int SEL_W = DATA_W / 8;

   logic              core_req_i;
   logic              core_we_i;
   logic [ADDR_W-1:0] core_addr_i;
   logic [DATA_W-1:0] core_wdata_i;
   logic [SEL_W-1:0]  core_be_i;
   logic              core_ready_o;
   logic              core_valid_o;
   logic [DATA_W-1:0] core_rdata_o;
   logic              core_err_o;
   logic              core_busy_o;

   logic              wb_cyc_o;
   logic              wb_stb_o;
   logic              wb_we_o;
   logic [ADDR_W-1:0] wb_adr_o;
   logic [DATA_W-1:0] wb_dat_o;
   logic [SEL_W-1:0]  wb_sel_o;
   logic [DATA_W-1:0] wb_dat_i;
   logic              wb_ack_i;
   logic              wb_err_i;

   modport master (
      input  core_req_i, core_we_i, core_addr_i, core_wdata_i, core_be_i,
      input  wb_dat_i, wb_ack_i, wb_err_i,
      output core_ready_o, core_valid_o, core_rdata_o, core_err_o, core_busy_o,
      output wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o
   );

   modport slave (
      output core_req_i, core_we_i, core_addr_i, core_wdata_i, core_be_i,
      output wb_dat_i, wb_ack_i, wb_err_i,
      input  core_ready_o, core_valid_o, core_rdata_o, core_err_o, core_busy_o,
      input  wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o
   );
endinterface

// File: rtl/wb_master_if.sv
// Wishbone classic single-transfer initiator. Accepts one core request in
// IDLE, runs one bus cycle until ack, err or timeout, then presents a
// one-cycle response strobe. One transaction outstanding at a time.
module wb_master_if #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 255
) (
   input logic            clk,
   input logic            rst,
   wb_master_if_if.master bus
);
   localparam int SEL_W = DATA_W / 8;
   // A zero timeout still needs a legal one-bit counter; it is never compared.
   localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_ACTIVE = 2'd1;
   localparam logic [1:0] S_RESP   = 2'd2;

   logic [1:0]        state_q, state_d;
   logic              cyc_q, cyc_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] adr_q, adr_d;
   logic [DATA_W-1:0] dat_q, dat_d;
   logic [SEL_W-1:0]  sel_q, sel_d;
   logic              valid_q, valid_d;
   logic              err_q, err_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              timeout_hit;

   // Timeout fires on the last permitted cycle of cyc/stb
   always_comb begin
      timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1));
   end

   // Next-state and next-output decode for the IDLE/ACTIVE/RESP sequence
   always_comb begin
      state_d = state_q;
      cyc_d   = cyc_q;
      we_d    = we_q;
      adr_d   = adr_q;
      dat_d   = dat_q;
      sel_d   = sel_q;
      valid_d = valid_q;
      err_d   = err_q;
      rdata_d = rdata_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE: begin
            valid_d = 1'b0;
            err_d   = 1'b0;
            if (bus.core_req_i) begin
               we_d    = bus.core_we_i;
               adr_d   = bus.core_addr_i;
               dat_d   = bus.core_wdata_i;
               sel_d   = bus.core_be_i;
               cyc_d   = 1'b1;
               cnt_d   = '0;
               state_d = S_ACTIVE;
            end
         end
         S_ACTIVE: begin
            if (cnt_q != '1) begin
               cnt_d = cnt_q + 1'b1;
            end
            if (bus.wb_err_i) begin
               // Error wins over a simultaneous ack; read data is not captured.
               cyc_d   = 1'b0;
               valid_d = 1'b1;
               err_d   = 1'b1;
               state_d = S_RESP;
            end else if (bus.wb_ack_i) begin
               cyc_d   = 1'b0;
               valid_d = 1'b1;
               err_d   = 1'b0;
               if (!we_q) begin
                  rdata_d = bus.wb_dat_i;
               end
               state_d = S_RESP;
            end else if (timeout_hit) begin
               cyc_d   = 1'b0;
               valid_d = 1'b1;
               err_d   = 1'b1;
               state_d = S_RESP;
            end
         end
         S_RESP: begin
            valid_d = 1'b0;
            err_d   = 1'b0;
            state_d = S_IDLE;
         end
         default: begin
            cyc_d   = 1'b0;
            valid_d = 1'b0;
            err_d   = 1'b0;
            state_d = S_IDLE;
         end
      endcase
   end

   // State and registered outputs; reset aborts any cycle with no response
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         cyc_q   <= 1'b0;
         we_q    <= 1'b0;
         adr_q   <= '0;
         dat_q   <= '0;
         sel_q   <= '0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
         rdata_q <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cyc_q   <= cyc_d;
         we_q    <= we_d;
         adr_q   <= adr_d;
         dat_q   <= dat_d;
         sel_q   <= sel_d;
         valid_q <= valid_d;
         err_q   <= err_d;
         rdata_q <= rdata_d;
         cnt_q   <= cnt_d;
      end
   end

   assign bus.core_ready_o = (state_q == S_IDLE);
   assign bus.core_busy_o  = (state_q != S_IDLE);
   assign bus.core_valid_o = valid_q;
   assign bus.core_err_o   = err_q;
   assign bus.core_rdata_o = rdata_q;
   assign bus.wb_cyc_o     = cyc_q;
   assign bus.wb_stb_o     = cyc_q;
   assign bus.wb_we_o      = we_q;
   assign bus.wb_adr_o     = adr_q;
   assign bus.wb_dat_o     = dat_q;
   assign bus.wb_sel_o     = sel_q;
endmodule

// File: tb/tb_wb_master_if.sv
// Self-checking bench for wb_master_if (TIMEOUT=8). A behavioural model
// predicts bus-cycle length, error flag and read data from the slave's
// chosen ack/err cycle numbers.
module tb_wb_master_if;
   localparam int TO = 8;

   logic clk;
   logic rst;
   int   checks;
   int   errors;
   logic [31:0] exp_rdata;

   wb_master_if_if #(.ADDR_W(32), .DATA_W(32)) bus ();

   wb_master_if #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Model: the bus cycle ends at the earliest of ack, err, or the timeout cycle.
   function automatic int mdl_len(input int ack_c, input int err_c);
      int r;
      r = TO;
      if (ack_c != 0 && ack_c < r) r = ack_c;
      if (err_c != 0 && err_c < r) r = err_c;
      return r;
   endfunction

   // Model: error when the slave errs on the ending cycle or nothing acked it.
   function automatic logic mdl_err(input int ack_c, input int err_c);
      int r;
      r = mdl_len(ack_c, err_c);
      return (err_c == r) || (ack_c != r);
   endfunction

   // Runs one transaction; the slave asserts ack/err in the given cyc cycle (1-based, 0 = never).
   task automatic do_txn(input logic we, input logic [31:0] adr, input logic [31:0] wd,
                         input logic [3:0] be, input int ack_c, input int err_c,
                         input logic [31:0] rd,
                         output int len, output bit stable, output int vld_cnt,
                         output logic err_seen, output logic [31:0] rdata_seen,
                         output logic err_after, output logic ready_resp, output bit hung);
      int guard;
      len = 0; stable = 1'b1; vld_cnt = 0; err_seen = 1'b0; rdata_seen = '0;
      err_after = 1'b0; ready_resp = 1'b0; hung = 1'b0;
      guard = 0;
      while (bus.core_ready_o !== 1'b1 && guard < 20) begin
         @(posedge clk); #1; guard++;
      end
      if (guard >= 20) hung = 1'b1;
      bus.core_req_i   = 1'b1;
      bus.core_we_i    = we;
      bus.core_addr_i  = adr;
      bus.core_wdata_i = wd;
      bus.core_be_i    = be;
      @(posedge clk); #1;
      bus.core_req_i   = 1'b0;
      bus.core_we_i    = $urandom_range(0, 1);
      bus.core_addr_i  = $urandom;
      bus.core_wdata_i = $urandom;
      bus.core_be_i    = 4'($urandom);
      guard = 0;
      while (bus.wb_cyc_o === 1'b1 && guard < 64) begin
         len++;
         if (bus.wb_stb_o !== 1'b1 || bus.wb_we_o !== we || bus.wb_adr_o !== adr ||
             bus.wb_dat_o !== wd || bus.wb_sel_o !== be || bus.core_ready_o !== 1'b0 ||
             bus.core_busy_o !== 1'b1 || bus.core_valid_o !== 1'b0)
            stable = 1'b0;
         bus.wb_ack_i = (len == ack_c);
         bus.wb_err_i = (len == err_c);
         bus.wb_dat_i = (len == ack_c) ? rd : $urandom;
         @(posedge clk); #1; guard++;
      end
      bus.wb_ack_i = 1'b0;
      bus.wb_err_i = 1'b0;
      if (guard >= 64) hung = 1'b1;
      if (bus.core_valid_o === 1'b1) vld_cnt++;
      err_seen   = bus.core_err_o;
      rdata_seen = bus.core_rdata_o;
      ready_resp = bus.core_ready_o;
      @(posedge clk); #1;
      if (bus.core_valid_o === 1'b1) vld_cnt++;
      err_after = bus.core_err_o;
   endtask

   task automatic test_reset;
      rst = 1'b0;
      #1 rst = 1'b1;
      @(posedge clk); @(posedge clk); #1;
      checks++;
      if (bus.core_ready_o !== 1'b1 || bus.core_busy_o !== 1'b0) begin
         errors++; $display("FAIL reset_ready: ready=%b busy=%b required ready=1 busy=0", bus.core_ready_o, bus.core_busy_o);
      end
      checks++;
      if (bus.wb_cyc_o !== 1'b0 || bus.wb_stb_o !== 1'b0 || bus.core_valid_o !== 1'b0 || bus.core_err_o !== 1'b0) begin
         errors++; $display("FAIL reset_ctrl: cyc=%b stb=%b valid=%b err=%b required all 0", bus.wb_cyc_o, bus.wb_stb_o, bus.core_valid_o, bus.core_err_o);
      end
      checks++;
      if (bus.core_rdata_o !== 32'h0 || bus.wb_adr_o !== 32'h0 || bus.wb_sel_o !== 4'h0 || bus.wb_we_o !== 1'b0) begin
         errors++; $display("FAIL reset_data: rdata=%h adr=%h sel=%h we=%b required zeros", bus.core_rdata_o, bus.wb_adr_o, bus.wb_sel_o, bus.wb_we_o);
      end
      #2 rst = 1'b0;
      exp_rdata = 32'h0;
      @(posedge clk); #1;
   endtask

   task automatic test_write_zero_wait;
      int len, vld; bit st, hung; logic e, ea, rr; logic [31:0] rd;
      do_txn(1'b1, 32'h0000_1004, 32'hA5A5_0F0F, 4'b0011, 1, 0, 32'h5555_AAAA,
             len, st, vld, e, rd, ea, rr, hung);
      checks++;
      if (hung || len != mdl_len(1, 0) || !st) begin
         errors++; $display("FAIL wr0_bus: len=%0d stable=%0b hung=%0b required len=%0d stable=1", len, st, hung, mdl_len(1, 0));
      end
      checks++;
      if (vld != 1 || e !== mdl_err(1, 0) || ea !== 1'b0 || rr !== 1'b0) begin
         errors++; $display("FAIL wr0_resp: valid_cycles=%0d err=%b err_after=%b ready=%b required 1/%b/0/0", vld, e, ea, rr, mdl_err(1, 0));
      end
      checks++;
      if (rd !== exp_rdata) begin
         errors++; $display("FAIL wr0_rdata: got %h required %h", rd, exp_rdata);
      end
   endtask

   task automatic test_read_wait;
      int len, vld; bit st, hung; logic e, ea, rr; logic [31:0] rd;
      do_txn(1'b0, 32'h0000_2000, 32'h0, 4'hF, 4, 0, 32'hDEAD_BEEF,
             len, st, vld, e, rd, ea, rr, hung);
      if (!mdl_err(4, 0)) exp_rdata = 32'hDEAD_BEEF;
      checks++;
      if (hung || len != 4 || !st) begin
         errors++; $display("FAIL rd3_bus: len=%0d stable=%0b required len=4 stable=1", len, st);
      end
      checks++;
      if (vld != 1 || e !== 1'b0 || rd !== exp_rdata) begin
         errors++; $display("FAIL rd3_resp: valid_cycles=%0d err=%b rdata=%h required 1/0/%h", vld, e, rd, exp_rdata);
      end
   endtask

   task automatic test_timeout;
      int len, vld; bit st, hung; logic e, ea, rr; logic [31:0] rd;
      do_txn(1'b0, 32'h0000_3000, 32'h0, 4'hF, 0, 0, 32'h1111_2222,
             len, st, vld, e, rd, ea, rr, hung);
      checks++;
      if (hung || len != TO || !st) begin
         errors++; $display("FAIL timeout_len: len=%0d stable=%0b required len=%0d", len, st, TO);
      end
      checks++;
      if (vld != 1 || e !== 1'b1 || ea !== 1'b0 || rd !== exp_rdata) begin
         errors++; $display("FAIL timeout_resp: valid_cycles=%0d err=%b err_after=%b rdata=%h required 1/1/0/%h", vld, e, ea, rd, exp_rdata);
      end
      do_txn(1'b0, 32'h0000_3004, 32'h0, 4'hF, 2, 0, 32'h0BAD_F00D,
             len, st, vld, e, rd, ea, rr, hung);
      exp_rdata = 32'h0BAD_F00D;
      checks++;
      if (hung || len != 2 || vld != 1 || e !== 1'b0 || rd !== exp_rdata) begin
         errors++; $display("FAIL after_timeout: len=%0d valid_cycles=%0d err=%b rdata=%h required 2/1/0/%h", len, vld, e, rd, exp_rdata);
      end
   endtask

   task automatic test_err_beats_ack;
      int len, vld; bit st, hung; logic e, ea, rr; logic [31:0] rd;
      do_txn(1'b0, 32'h0000_4000, 32'h0, 4'hF, 3, 3, 32'h1234_5678,
             len, st, vld, e, rd, ea, rr, hung);
      checks++;
      if (hung || len != mdl_len(3, 3) || vld != 1 || e !== 1'b1 || rd !== exp_rdata) begin
         errors++; $display("FAIL err_vs_ack: len=%0d valid_cycles=%0d err=%b rdata=%h required 3/1/1/%h", len, vld, e, rd, exp_rdata);
      end
   endtask

   task automatic test_async_reset;
      int len, vld, bad_v; bit st, hung; logic e, ea, rr; logic [31:0] rd;
      bus.core_req_i  = 1'b1;
      bus.core_we_i   = 1'b0;
      bus.core_addr_i = 32'h0000_5000;
      bus.core_be_i   = 4'hF;
      @(posedge clk); #1;
      bus.core_req_i = 1'b0;
      @(posedge clk); #2;
      rst = 1'b1;
      #1;
      checks++;
      if (bus.wb_cyc_o !== 1'b0 || bus.wb_stb_o !== 1'b0 || bus.core_valid_o !== 1'b0 || bus.core_ready_o !== 1'b1) begin
         errors++; $display("FAIL async_rst_drop: cyc=%b stb=%b valid=%b ready=%b required 0/0/0/1", bus.wb_cyc_o, bus.wb_stb_o, bus.core_valid_o, bus.core_ready_o);
      end
      @(posedge clk); #2;
      rst = 1'b0;
      exp_rdata = 32'h0;
      bad_v = 0;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         if (bus.core_valid_o !== 1'b0 || bus.wb_cyc_o !== 1'b0 || bus.core_ready_o !== 1'b1) bad_v++;
      end
      checks++;
      if (bad_v != 0) begin
         errors++; $display("FAIL async_rst_quiet: bad_cycles=%0d required 0", bad_v);
      end
      do_txn(1'b1, 32'h0000_5004, 32'hCAFE_0001, 4'b1100, 2, 0, 32'h0,
             len, st, vld, e, rd, ea, rr, hung);
      checks++;
      if (hung || len != 2 || !st || vld != 1 || e !== 1'b0 || rd !== exp_rdata) begin
         errors++; $display("FAIL async_rst_after: len=%0d stable=%0b valid_cycles=%0d err=%b rdata=%h required 2/1/1/0/%h", len, st, vld, e, rd, exp_rdata);
      end
   endtask

   task automatic test_back_to_back;
      int rises[$];
      int vld;
      bit prev_cyc, prev_vld, dbl, adr_ok;
      vld = 0; prev_cyc = 1'b0; prev_vld = 1'b0; dbl = 1'b0; adr_ok = 1'b1;
      bus.core_req_i   = 1'b1;
      bus.core_we_i    = 1'b1;
      bus.core_addr_i  = 32'h10;
      bus.core_wdata_i = $urandom;
      bus.core_be_i    = 4'hF;
      bus.wb_ack_i     = 1'b1;
      for (int cyc_n = 1; cyc_n <= 14; cyc_n++) begin
         @(posedge clk); #1;
         if (bus.wb_cyc_o === 1'b1 && !prev_cyc) begin
            rises.push_back(cyc_n);
            if (bus.wb_adr_o !== ((rises.size() == 1) ? 32'h10 : 32'h14)) adr_ok = 1'b0;
            if (rises.size() == 1) bus.core_addr_i = 32'h14;
            else bus.core_req_i = 1'b0;
         end
         if (bus.core_valid_o === 1'b1) begin
            vld++;
            if (prev_vld) dbl = 1'b1;
         end
         prev_vld = (bus.core_valid_o === 1'b1);
         prev_cyc = (bus.wb_cyc_o === 1'b1);
      end
      bus.wb_ack_i   = 1'b0;
      bus.core_req_i = 1'b0;
      checks++;
      if (rises.size() != 2 || !adr_ok) begin
         errors++; $display("FAIL b2b_cycles: bus_cycles=%0d adr_ok=%0b required 2/1", rises.size(), adr_ok);
      end
      checks++;
      if (rises.size() == 2 && (rises[1] - rises[0]) < 3) begin
         errors++; $display("FAIL b2b_spacing: spacing=%0d required >=3", rises[1] - rises[0]);
      end
      checks++;
      if (vld != 2 || dbl || bus.core_rdata_o !== exp_rdata) begin
         errors++; $display("FAIL b2b_resp: valid_pulses=%0d double=%0b rdata=%h required 2/0/%h", vld, dbl, bus.core_rdata_o, exp_rdata);
      end
   endtask

   task automatic test_random;
      int len, vld, a, e_c, mode; bit st, hung; logic e, ea, rr, we; logic [31:0] rd, rdv;
      for (int i = 0; i < 24; i++) begin
         we = $urandom_range(0, 1);
         mode = $urandom_range(0, 3);
         a = 0; e_c = 0;
         case (mode)
            0: a = $urandom_range(1, 6);
            1: e_c = $urandom_range(1, 6);
            2: begin a = $urandom_range(1, 10); e_c = $urandom_range(1, 10); end
            default: ;
         endcase
         rdv = $urandom;
         do_txn(we, $urandom, $urandom, 4'($urandom), a, e_c, rdv,
                len, st, vld, e, rd, ea, rr, hung);
         if (!we && !mdl_err(a, e_c)) exp_rdata = rdv;
         checks++;
         if (hung || len != mdl_len(a, e_c) || !st) begin
            errors++; $display("FAIL rnd%0d_bus: len=%0d stable=%0b required len=%0d (ack=%0d err=%0d)", i, len, st, mdl_len(a, e_c), a, e_c);
         end
         checks++;
         if (vld != 1 || e !== mdl_err(a, e_c) || ea !== 1'b0) begin
            errors++; $display("FAIL rnd%0d_resp: valid_cycles=%0d err=%b err_after=%b required 1/%b/0", i, vld, e, ea, mdl_err(a, e_c));
         end
         checks++;
         if (rd !== exp_rdata) begin
            errors++; $display("FAIL rnd%0d_rdata: got %h required %h", i, rd, exp_rdata);
         end
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      exp_rdata = 32'h0;
      bus.core_req_i   = 1'b0;
      bus.core_we_i    = 1'b0;
      bus.core_addr_i  = '0;
      bus.core_wdata_i = '0;
      bus.core_be_i    = '0;
      bus.wb_dat_i     = '0;
      bus.wb_ack_i     = 1'b0;
      bus.wb_err_i     = 1'b0;
      test_reset();
      test_write_zero_wait();
      test_read_wait();
      test_timeout();
      test_err_beats_ack();
      test_async_reset();
      test_back_to_back();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/wb_master_if.md
Name: wb_master_if

Overview:
- Wishbone classic single-transfer bus initiator between the RV32I datapath and memory-mapped slaves such as the RSA accelerator.
- Converts a simple core request (address, data, byte enables, read/write) into one wishbone cycle.
- Waits for the slave's ack or error, or for a timeout, then returns a one-cycle response to the core.
- Supports one outstanding transaction.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; SEL_W = DATA_W/8.
- TIMEOUT, 255, maximum cycles with cyc/stb high before aborting; 0 disables the timeout.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- core_req_i  in  1  core request valid.
- core_we_i  in  1  1 = write, 0 = read.
- core_addr_i  in  ADDR_W  byte address.
- core_wdata_i  in  DATA_W  write data.
- core_be_i  in  SEL_W  byte enables.
- core_ready_o  out  1  initiator can accept a request this cycle.
- core_valid_o  out  1  one-cycle response strobe.
- core_rdata_o  out  DATA_W  read data, valid with core_valid_o on a read.
- core_err_o  out  1  response is an error (slave err or timeout); valid with core_valid_o.
- core_busy_o  out  1  transaction in flight (state != IDLE).
- wb_cyc_o, wb_stb_o  out  1  bus cycle / strobe.
- wb_we_o  out  1  write enable.
- wb_adr_o  out  ADDR_W  address.
- wb_dat_o  out  DATA_W  write data.
- wb_sel_o  out  SEL_W  byte select.
- wb_dat_i  in  DATA_W  read data from slave.
- wb_ack_i  in  1  slave acknowledge.
- wb_err_i  in  1  slave error.

Behaviour:
- Reset (async, immediate): state=IDLE; all outputs 0 except core_ready_o=1; rdata=0; timeout counter=0.
- Reset mid-transaction drops wb_cyc_o/wb_stb_o at once, and no response is issued.
- All wb_* and core_* outputs come from registers, except core_ready_o and core_busy_o, which decode from state.
- FSM states: IDLE, ACTIVE, RESP.
- IDLE:
  - core_ready_o=1.
  - If core_req_i=1 at a posedge: latch addr/wdata/be/we into the wb_* registers; set cyc=stb=1; clear the counter; go ACTIVE.
  - Bus outputs are therefore valid in the cycle after acceptance.
- ACTIVE:
  - core_ready_o=0; wb_adr/dat/sel/we held stable.
  - Counter increments each cycle, saturating.
  - wb_err_i=1: go RESP with err=1, rdata unchanged. Err takes priority over a simultaneous ack.
  - Else wb_ack_i=1: go RESP with err=0. On a read, capture wb_dat_i into core_rdata_o; on a write, rdata is unchanged.
  - Else if TIMEOUT!=0 and counter==TIMEOUT-1: go RESP with err=1.
  - Every exit from ACTIVE clears cyc/stb at the same edge.
- RESP:
  - core_valid_o=1 for exactly one cycle; core_ready_o=0; go IDLE at the next edge.
  - core_err_o is cleared when leaving RESP.
- Latency: request accepted at edge E0, slave ack sampled at edge Ek → core_valid_o high in cycle Ek..Ek+1, ready high again after Ek+1.
  - Minimum issue interval is 3 cycles (zero-wait slave acks in the first cycle cyc is high).
- A request held high continuously is accepted once per IDLE visit.
- wb_ack_i/wb_err_i in IDLE or RESP are ignored: no state change, no rdata capture.
- core_* inputs are don't-care outside IDLE.
- core_rdata_o holds the last successful read value indefinitely.
- Counter width is $clog2(TIMEOUT+1); it is never compared when TIMEOUT=0, so a stuck slave hangs forever by design.

Test Plan:
- Write, zero-wait: addr=0x0000_1004, wdata=0xA5A5_0F0F, be=4'b0011; slave acks in the first cyc cycle → wb_sel_o=0011 and wb_dat_o=0xA5A5_0F0F during cyc; core_valid_o=1 with err=0 exactly 2 cycles after acceptance; rdata unchanged.
- Read, 3 wait states: slave returns 0xDEAD_BEEF with ack in the 4th cyc cycle → core_rdata_o=0xDEAD_BEEF, err=0; cyc held exactly 4 cycles; adr stable throughout.
- Timeout, TIMEOUT=8, slave never acks → cyc high exactly 8 cycles; then core_valid_o=1, core_err_o=1, rdata unchanged; next request accepted normally.
- Error beats ack: wb_err_i and wb_ack_i both high in the same cycle on a read of 0x1234_5678 → err=1, rdata keeps its prior value.
- Async reset mid-cycle: assert rst 2 cycles into an ACTIVE read → cyc/stb go 0 within the same cycle, no core_valid_o; after release core_ready_o=1 and a new write completes normally.
- Back-to-back with a spurious ack: core_req_i held high with addresses 0x10 then 0x14; a stray wb_ack_i is injected in IDLE → exactly two bus cycles; the stray ack causes no response; accept-to-accept spacing ≥3 cycles.
